// File: rtl/matrix_pkg.sv
// Shared panel-path constants, swap FSM encoding, pixel payload type and gamma table.
package matrix_pkg;

  localparam int unsigned COL_WIDTH   = 6;
  localparam int unsigned ROW_WIDTH   = 4;
  localparam int unsigned COLOR_WIDTH = 8;
  localparam int unsigned PLANES      = 6;
  localparam int unsigned ADDR_WIDTH  = 1 + ROW_WIDTH + COL_WIDTH;
  localparam int unsigned PIXEL_WIDTH = 3 * COLOR_WIDTH;

  localparam logic [0:0] SWAP_IDLE    = 1'b0;
  localparam logic [0:0] SWAP_PENDING = 1'b1;

  typedef struct packed {
    logic [COLOR_WIDTH-1:0] r;
    logic [COLOR_WIDTH-1:0] g;
    logic [COLOR_WIDTH-1:0] b;
  } rgb888_t;

  // Gamma ~2.0 table: top PLANES bits of ch*ch, so 0 -> 0 and full scale -> 63.
  function automatic logic [PLANES-1:0] gamma_lut(input logic [COLOR_WIDTH-1:0] ch);
    logic [2*COLOR_WIDTH-1:0] sq;
    sq = (2*COLOR_WIDTH)'(ch) * (2*COLOR_WIDTH)'(ch);
    return sq[2*COLOR_WIDTH-1 -: PLANES];
  endfunction

endpackage

// File: rtl/matrix_plane_select.sv
// One RGB888 word plus bit-plane mask to three plane bits {r,g,b}; purely combinational.
module matrix_plane_select
  import matrix_pkg::*;
#(
  parameter bit GAMMA_EN = 1'b1
) (
  input  rgb888_t           pixel,
  input  logic [PLANES-1:0] mask,
  output logic [2:0]        bits_c
);

  logic [PLANES-1:0] level_r;
  logic [PLANES-1:0] level_g;
  logic [PLANES-1:0] level_b;

  always_comb begin
    if (GAMMA_EN) begin
      level_r = gamma_lut(pixel.r);
      level_g = gamma_lut(pixel.g);
      level_b = gamma_lut(pixel.b);
    end else begin
      level_r = pixel.r[COLOR_WIDTH-1 -: PLANES];
      level_g = pixel.g[COLOR_WIDTH-1 -: PLANES];
      level_b = pixel.b[COLOR_WIDTH-1 -: PLANES];
    end
    // Multi-hot masks simply OR the selected planes together.
    bits_c = {|(level_r & mask), |(level_g & mask), |(level_b & mask)};
  end

endmodule

// File: rtl/matrix_pixel_fetch.sv
// Scanner-to-shift-chain data stage: framebuffer fetch, plane select, double-buffer swap.
module matrix_pixel_fetch
  import matrix_pkg::*;
#(
  parameter bit GAMMA_EN = 1'b1
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   pixel_load,
  input  logic [COL_WIDTH-1:0]   column_address,
  input  logic [ROW_WIDTH-1:0]   row_address,
  input  logic [PLANES-1:0]      brightness_mask,
  output logic                   fb_rd_en,
  output logic [ADDR_WIDTH-1:0]  fb_rd_addr,
  input  logic [PIXEL_WIDTH-1:0] fb_top_data,
  input  logic [PIXEL_WIDTH-1:0] fb_bot_data,
  output logic [2:0]             rgb_top,
  output logic [2:0]             rgb_bot,
  output logic                   pixel_valid,
  input  logic                   swap_req,
  output logic                   swap_ack,
  output logic                   display_buffer
);

  logic [0:0]        state;
  logic [0:0]        state_next;
  logic              frame_boundary;
  logic              swap_take;
  logic              valid_s1;
  logic [PLANES-1:0] mask_s1;
  logic [2:0]        top_bits_c;
  logic [2:0]        bot_bits_c;
  rgb888_t           top_px;
  rgb888_t           bot_px;

  assign frame_boundary = pixel_load && (row_address == '0) && (column_address == '1)
                          && (brightness_mask == PLANES'(1));

  // Swap FSM: arm on request, take it on the first frame-boundary load while still requested.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) state <= SWAP_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    swap_take  = 1'b0;
    case (state)
      SWAP_IDLE: begin
        if (swap_req) state_next = SWAP_PENDING;
      end
      SWAP_PENDING: begin
        if (!swap_req) begin
          state_next = SWAP_IDLE;
        end else if (frame_boundary) begin
          swap_take  = 1'b1;
          state_next = SWAP_IDLE;
        end
      end
      default: state_next = SWAP_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset)         display_buffer <= 1'b0;
    else if (swap_take) display_buffer <= ~display_buffer;
  end

  // The boundary load itself already reads from the newly selected buffer.
  assign swap_ack   = swap_take;
  assign fb_rd_en   = pixel_load;
  assign fb_rd_addr = {display_buffer ^ swap_take, row_address, column_address};

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      valid_s1 <= 1'b0;
      mask_s1  <= '0;
    end else begin
      valid_s1 <= pixel_load;
      mask_s1  <= brightness_mask;
    end
  end

  assign top_px = fb_top_data;
  assign bot_px = fb_bot_data;

  matrix_plane_select #(.GAMMA_EN(GAMMA_EN)) u_sel_top (
    .pixel  (top_px),
    .mask   (mask_s1),
    .bits_c (top_bits_c)
  );

  matrix_plane_select #(.GAMMA_EN(GAMMA_EN)) u_sel_bot (
    .pixel  (bot_px),
    .mask   (mask_s1),
    .bits_c (bot_bits_c)
  );

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      pixel_valid <= 1'b0;
      rgb_top     <= '0;
      rgb_bot     <= '0;
    end else begin
      pixel_valid <= valid_s1;
      rgb_top     <= valid_s1 ? top_bits_c : 3'b000;
      rgb_bot     <= valid_s1 ? bot_bits_c : 3'b000;
    end
  end

endmodule
